layer_tdm: RTL and testbench

Time-multiplexed fully-connected layer: computes `numNeurons` fixed-point neuron outputs from one `numInputs`-wide input vector. It uses `numLanes` parallel MAC lanes over `numNeurons/numLanes` sequential passes. All weights and biases come from two shared ROM images. It sits between consecutive layers in the network pipeline and replaces per-neuron instances with a ready/valid-handshaked, lane-scalable datapath that supports optional ReLU.

---
 rtl/layer_pkg.sv | 14 +
 rtl/mac_lane.sv | 38 +++
 rtl/layer_tdm.sv | 118 +++++++++++
 tb/tb_layer_tdm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: shared FSM/activation types and fixed-point helpers for the time-multiplexed layer.
package layer_pkg;
  typedef enum logic [2:0] {IDLE, PRIME, MAC, FINISH, DONE} state_t;
  typedef enum logic {ACT_IDENTITY, ACT_RELU} act_t;
  function automatic int accWidth(int dataWidth, int weightWidth, int numInputs);
    return dataWidth + weightWidth + $clog2(numInputs);
  endfunction
  function automatic logic signed [63:0] sat(logic signed [63:0] v, int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed MAC lane; accumulates x*w, then rescales, adds bias, saturates and activates.
module mac_lane
  import layer_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int dataFracWidth = 10,
  parameter int weightWidth = 16,
  parameter int weightFracWidth = 10,
  parameter int numInputs = 784,
  parameter int actMode = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic [dataWidth-1:0]   x,
  input  logic [weightWidth-1:0] w,
  input  logic [weightWidth-1:0] bias,
  output logic [dataWidth-1:0]   result
);
  localparam int accW = accWidth(dataWidth, weightWidth, numInputs);
  localparam int prodW = dataWidth + weightWidth;
  localparam int biasUp = dataFracWidth >= weightFracWidth ? dataFracWidth - weightFracWidth : 0;
  localparam int biasDn = weightFracWidth > dataFracWidth ? weightFracWidth - dataFracWidth : 0;
  localparam act_t act = act_t'(actMode);
  logic signed [accW-1:0] acc;
  logic signed [prodW-1:0] prod;
  logic signed [accW:0] biasAligned, sum;
  assign prod = prodW'($signed(x)) * prodW'($signed(w));
  // bias is brought from the weight Q format into the data Q format before the add
  assign biasAligned = ((accW + 1)'($signed(bias)) <<< biasUp) >>> biasDn;
  assign sum = (accW + 1)'(acc >>> weightFracWidth) + biasAligned;
  assign result = (act == ACT_RELU && sum[accW]) ? '0 : dataWidth'(sat(64'(sum), dataWidth));
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clear) acc <= '0;
    else if (en) acc <= acc + accW'(prod);
endmodule

// File: rtl/layer_tdm.sv
// layer_tdm: fully-connected layer computing numNeurons outputs with numLanes MAC lanes over numNeurons/numLanes passes.
module layer_tdm
  import layer_pkg::*;
#(
  parameter int numInputs = 784,
  parameter int numNeurons = 16,
  parameter int numLanes = 4,
  parameter int dataWidth = 16,
  parameter int dataFracWidth = 10,
  parameter int weightWidth = 16,
  parameter int weightFracWidth = 10,
  parameter int actMode = 1,
  parameter string weightFile = "weights/weight_L0.mif",
  parameter string biasFile = "bias/bias_L0.mif"
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [dataWidth*numInputs-1:0]  layerIn,
  input  logic                            layerValid,
  output logic                            layerReady,
  output logic [dataWidth*numNeurons-1:0] layerOut,
  output logic                            layerOutValid,
  input  logic                            layerOutReady
);
  localparam int numPasses = numNeurons / numLanes;
  localparam int romDepth = numPasses * numInputs;
  localparam int addrW = romDepth > 1 ? $clog2(romDepth) : 1;
  localparam int passW = numPasses > 1 ? $clog2(numPasses) : 1;
  localparam int idxW = numInputs > 1 ? $clog2(numInputs) : 1;
  localparam int romW = numLanes * weightWidth;
  logic [romW-1:0] weightRom [romDepth];
  logic [romW-1:0] biasRom [numPasses];
  state_t state, nextState;
  logic [passW-1:0] pass;
  logic [idxW-1:0] idx;
  logic [dataWidth*numInputs-1:0] inVec;
  logic [romW-1:0] weightData, biasData;
  logic [addrW-1:0] weightAddr;
  logic [dataWidth-1:0] laneOut [numLanes];
  logic lastIdx, lastPass, clear, macEn, finish;
  assign lastIdx = idx == idxW'(numInputs - 1);
  assign lastPass = pass == passW'(numPasses - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    layerReady = 1'b0;
    layerOutValid = 1'b0;
    clear = 1'b0;
    macEn = 1'b0;
    finish = 1'b0;
    unique case (state)
      IDLE: begin
        layerReady = 1'b1;
        nextState = layerValid ? PRIME : IDLE;
      end
      PRIME: begin
        clear = 1'b1;
        nextState = MAC;
      end
      MAC: begin
        macEn = 1'b1;
        nextState = lastIdx ? FINISH : MAC;
      end
      FINISH: begin
        finish = 1'b1;
        nextState = lastPass ? DONE : PRIME;
      end
      DONE: begin
        layerOutValid = 1'b1;
        nextState = layerOutReady ? IDLE : DONE;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pass <= '0;
      idx <= '0;
      inVec <= '0;
    end else begin
      if (layerReady && layerValid) begin
        inVec <= layerIn;
        pass <= '0;
      end
      if (clear) idx <= '0;
      else if (macEn) idx <= idx + idxW'(1);
      if (finish && !lastPass) pass <= pass + passW'(1);
    end
  assign weightAddr = addrW'(pass * numInputs) + addrW'(macEn && !lastIdx ? idx + idxW'(1) : idxW'(0));
  always_ff @(posedge clk) begin
    weightData <= weightRom[weightAddr];
    biasData <= biasRom[pass];
  end
  genvar l;
  for (l = 0; l < numLanes; l++) begin : gLane
    mac_lane #(
      .dataWidth(dataWidth), .dataFracWidth(dataFracWidth),
      .weightWidth(weightWidth), .weightFracWidth(weightFracWidth),
      .numInputs(numInputs), .actMode(actMode)
    ) uLane (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .en(macEn),
      .x(inVec[idx*dataWidth +: dataWidth]),
      .w(weightData[l*weightWidth +: weightWidth]),
      .bias(biasData[l*weightWidth +: weightWidth]),
      .result(laneOut[l])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) layerOut <= '0;
    else if (finish)
      for (int k = 0; k < numLanes; k++)
        layerOut[(pass*numLanes + k)*dataWidth +: dataWidth] <= laneOut[k];
endmodule

// File: tb/tb_layer_tdm.sv
// tb_layer_tdm: ReLU and identity instances driven in lockstep, checked against a neuron-level model.
module tb_layer_tdm;
  localparam int IN = 4, NEU = 4, LANES = 2, P = NEU / LANES, DW = 16;
  logic clk = 0, reset = 0, layerValid = 0, layerOutReady = 0;
  logic [DW*IN-1:0] layerIn = '0;
  logic readyRelu, readyLin, validRelu, validLin;
  logic [DW*NEU-1:0] outRelu, outLin;
  logic [15:0] wRom [P*IN][LANES];
  logic [15:0] bRom [P][LANES];
  int checks = 0, failures = 0;

  layer_tdm #(.numInputs(IN), .numNeurons(NEU), .numLanes(LANES), .dataWidth(16), .dataFracWidth(10),
    .weightWidth(16), .weightFracWidth(10), .actMode(1), .weightFile(""), .biasFile("")) dutRelu (
    .clk(clk), .reset(reset), .layerIn(layerIn), .layerValid(layerValid), .layerReady(readyRelu),
    .layerOut(outRelu), .layerOutValid(validRelu), .layerOutReady(layerOutReady));
  layer_tdm #(.numInputs(IN), .numNeurons(NEU), .numLanes(LANES), .dataWidth(16), .dataFracWidth(10),
    .weightWidth(16), .weightFracWidth(10), .actMode(0), .weightFile(""), .biasFile("")) dutLin (
    .clk(clk), .reset(reset), .layerIn(layerIn), .layerValid(layerValid), .layerReady(readyLin),
    .layerOut(outLin), .layerOutValid(validLin), .layerOutReady(layerOutReady));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // neuron n = pass*LANES + lane; plain integer dot product, floor rescale, clamp, optional ReLU
  function automatic logic [63:0] model(input logic [63:0] vec, input bit relu);
    logic [63:0] r;
    longint acc, v;
    int p, l;
    r = '0;
    for (int n = 0; n < NEU; n++) begin
      p = n / LANES;
      l = n % LANES;
      acc = 0;
      for (int i = 0; i < IN; i++)
        acc += longint'($signed(vec[i*DW +: DW])) * longint'($signed(wRom[p*IN+i][l]));
      v = (acc >>> 10) + longint'($signed(bRom[p][l]));
      v = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
      if (relu && v < 0) v = 0;
      r[n*DW +: DW] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd();
    return $urandom_range(0, 1) ? 16'($urandom) : 16'($signed(12'($urandom)));
  endfunction

  function automatic logic [63:0] randVec();
    logic [63:0] v;
    for (int i = 0; i < IN; i++) v[i*DW +: DW] = rnd();
    return v;
  endfunction

  task automatic loadRoms();
    logic [DW*LANES-1:0] word;
    for (int a = 0; a < P*IN; a++) begin
      for (int l = 0; l < LANES; l++) word[l*DW +: DW] = wRom[a][l];
      dutRelu.weightRom[a] = word;
      dutLin.weightRom[a] = word;
    end
    for (int p = 0; p < P; p++) begin
      for (int l = 0; l < LANES; l++) word[l*DW +: DW] = bRom[p][l];
      dutRelu.biasRom[p] = word;
      dutLin.biasRom[p] = word;
    end
  endtask

  task automatic setRoms(input logic [15:0] w, input logic [15:0] bStep);
    for (int a = 0; a < P*IN; a++)
      for (int l = 0; l < LANES; l++) wRom[a][l] = w;
    for (int p = 0; p < P; p++)
      for (int l = 0; l < LANES; l++) bRom[p][l] = 16'(bStep * (p*LANES + l));
    loadRoms();
  endtask

  task automatic randRoms();
    for (int a = 0; a < P*IN; a++)
      for (int l = 0; l < LANES; l++) wRom[a][l] = rnd();
    for (int p = 0; p < P; p++)
      for (int l = 0; l < LANES; l++) bRom[p][l] = rnd();
    loadRoms();
  endtask

  task automatic runCase(input string tag, input logic [63:0] vec, input int hold, input bit disturb,
                         input logic [63:0] expRelu, input logic [63:0] expLin);
    int lat;
    @(negedge clk);
    layerIn = vec;
    layerValid = 1;
    check({tag, "/ready"}, {readyRelu, readyLin}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    layerValid = 0;
    if (disturb) layerIn = ~vec;
    lat = 0;
    while (!validRelu && lat < 100) begin
      @(negedge clk);
      lat++;
      layerValid = disturb && lat == 4;
      if (disturb) layerIn = randVec();
    end
    layerValid = 0;
    check({tag, "/latency"}, lat, 12);
    for (int c = 0; c <= hold; c++) begin
      check({tag, "/outRelu"}, outRelu, expRelu);
      check({tag, "/outLin"}, outLin, expLin);
      check({tag, "/doneFlags"}, {validRelu, validLin, readyRelu, readyLin}, 4'b1100);
      if (c < hold) @(negedge clk);
    end
    layerOutReady = 1;
    @(negedge clk);
    layerOutReady = 0;
    check({tag, "/idleFlags"}, {validRelu, validLin, readyRelu, readyLin}, 4'b0011);
  endtask

  initial begin
    logic [63:0] vec;
    repeat (3) @(negedge clk);
    check("reset/outRelu", outRelu, 64'h0);
    check("reset/outLin", outLin, 64'h0);
    check("reset/flags", {validRelu, validLin, readyRelu, readyLin}, 4'b0011);
    reset = 1;
    setRoms(16'h0200, 16'h0000);
    runCase("uniform", {4{16'h0400}}, 0, 0, {4{16'h0800}}, {4{16'h0800}});
    setRoms(16'h0000, 16'h0400);
    runCase("biasOrder", {4{16'h0400}}, 0, 0, 64'h0C00_0800_0400_0000, 64'h0C00_0800_0400_0000);
    setRoms(16'hFC00, 16'h0000);
    runCase("negative", {4{16'h0400}}, 0, 0, 64'h0, {4{16'hF000}});
    setRoms(16'h7FFF, 16'h0000);
    runCase("saturate", {4{16'h7FFF}}, 0, 0, {4{16'h7FFF}}, {4{16'h7FFF}});
    randRoms();
    vec = randVec();
    runCase("backpressure", vec, 10, 0, model(vec, 1), model(vec, 0));
    randRoms();
    vec = randVec();
    runCase("isolation", vec, 0, 1, model(vec, 1), model(vec, 0));
    // abort during pass 1 MAC
    randRoms();
    @(negedge clk);
    layerIn = randVec();
    layerValid = 1;
    @(posedge clk);
    @(negedge clk);
    layerValid = 0;
    repeat (8) @(negedge clk);
    reset = 0;
    #1;
    check("midReset/outRelu", outRelu, 64'h0);
    check("midReset/outLin", outLin, 64'h0);
    check("midReset/flags", {validRelu, validLin, readyRelu, readyLin}, 4'b0011);
    @(negedge clk);
    reset = 1;
    vec = randVec();
    runCase("afterReset", vec, 0, 0, model(vec, 1), model(vec, 0));
    for (int t = 0; t < 12; t++) begin
      randRoms();
      vec = randVec();
      runCase("random", vec, $urandom_range(0, 3), 0, model(vec, 1), model(vec, 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
